ca_code_gen: RTL and testbench
==============================

Name: ca_code_gen

Overview:
GPS L1 C/A Gold-code generator, driven by the code-rate DDS phase-accumulator MSB. Rising MSB edges advance the code by one chip; both edges advance the half-chip early/prompt/late delay line. Outputs feed the per-channel correlator mixers and the code-phase/epoch bookkeeping of the tracking channel.

Parameters:
CODE_LENGTH, 1023, chips per epoch; sets the code_phase wrap point. Non-default values are for shortened-bench use only.
PHASE_WIDTH, 10, code_phase counter width; must satisfy 2^PHASE_WIDTH >= CODE_LENGTH.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
enable  input  1  when low, DDS edges are ignored; all state holds
init  input  1  synchronous one-cycle reload strobe; latches prn
prn  input  6  satellite PRN select 1..32; sampled only on init
nco_msb  input  1  top bit of the code DDS output
code_early  output  1  early chip, 1/2 chip ahead of prompt
code_prompt  output  1  prompt chip
code_late  output  1  late chip, 1/2 chip behind prompt
code_phase  output  PHASE_WIDTH  chip index of code_early, 0..CODE_LENGTH-1
epoch  output  1  one-cycle pulse when code_phase wraps to 0

Behaviour:
- Reset (reset low, async) forces the following; all other outputs follow from this state:
  - G1 = G2 = all ones
  - prn_q = 1
  - code_phase = 0
  - code_prompt = code_late = 0
  - epoch = 0
  - msb_d = 0
- Edge detection:
  - msb_d <= nco_msb every cycle, regardless of enable.
  - rise = nco_msb & ~msb_d; fall = ~nco_msb & msb_d.
  - Events act only when enable = 1.
- G1: 10-stage shift, stages 1..10. Feedback = s3 ^ s10 into s1; output s10.
- G2: feedback = s2^s3^s6^s8^s9^s10 into s1.
  - G2i = G2[tapA] ^ G2[tapB], using the IS-GPS-200 Table 3-Ia pair for prn_q (PRN1 = 2,6; PRN2 = 3,7; ... PRN32 = 4,9), held in a 32-entry case table.
- code_early = G1.s10 ^ G2i, combinational from registered state.
  - All-ones state gives 1, so every PRN starts with chip 1.
- On rise:
  - G1 and G2 shift once.
  - code_phase increments.
  - If code_phase == CODE_LENGTH-1, code_phase <= 0, G1 and G2 <= all ones (forced realign), and epoch <= 1 the next cycle.
- On rise or fall:
  - code_late <= code_prompt.
  - code_prompt <= code_early (value before any same-cycle shift).
- epoch is high for exactly one clk per wrap. Otherwise 0.
- init = 1 (priority over rise/fall that cycle):
  - prn_q <= prn.
  - G1 and G2 <= all ones.
  - code_phase <= 0.
  - code_prompt = code_late <= 0.
  - epoch <= 0.
  - msb_d still updates.
  - init acts regardless of enable.
- prn outside 1..32 when init is sampled: prn_q is stored, code_early is forced to 0, and counters and epoch run normally.
- nco_msb must toggle no faster than every 2 clk. Each cycle handles at most one edge.
- Latency: a rise at cycle n (nco_msb high, msb_d low) updates code_early/code_phase at n+1 and code_prompt at n+1 to the pre-shift early value.

Test Plan:
- PRN1: init with prn=1, enable=1, nco_msb toggling every 4 clk -> code_early over chips 0..9 = 1,1,0,0,1,0,0,0,0,0 (octal 1440); code_phase 0..9.
- PRN 1,7,19,32, one full epoch each -> 1023-chip sequence matches a golden IS-GPS-200 model; exactly one epoch pulse per epoch, coincident with code_phase 1022->0; the next chip is 1 again.
- Half-chip spacing: capture sequences on the cycle after each edge -> code_prompt equals code_early delayed by one edge; code_late equals code_prompt delayed by one edge.
- enable=0 for 40 clk while nco_msb keeps toggling -> code_phase, G1/G2, prompt and late frozen; after re-enable, the first rise advances exactly one chip (no burst).
- init at code_phase 500, simultaneous with a rise, with prn=5 -> code_phase=0, first chip 1, PRN5 sequence thereafter; no epoch pulse.
- Async reset asserted mid-code between clk edges -> outputs immediately show reset values; prn=40 at init -> code_early stuck at 0 while epoch still pulses every 1023 rises.

Source files
------------

// File: rtl/ca_code_gen.sv
`default_nettype none
// ============================================================================
// Module      : ca_code_gen
// Description : GPS L1 C/A Gold-code generator paced by the code DDS MSB.
//               A rising DDS MSB edge advances the code one chip. Either
//               edge advances the half-chip early -> prompt -> late line.
//
//               Ports
//                 clk          system clock
//                 reset        asynchronous active-low reset
//                 enable       when low, DDS edges are ignored
//                 init         one-cycle reload strobe; latches prn
//                 prn[5:0]     satellite PRN select (1..32 valid)
//                 nco_msb      top bit of the code DDS accumulator
//                 code_early   early chip, half a chip ahead of prompt
//                 code_prompt  prompt chip
//                 code_late    late chip, half a chip behind prompt
//                 code_phase   chip index of code_early
//                 epoch        one-cycle pulse when code_phase wraps to 0
// Revision    : 1.0 - initial release
// ============================================================================
module ca_code_gen #(
    parameter int unsigned CODE_LENGTH = 1023,
    parameter int unsigned PHASE_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   init,
    input  logic [5:0]             prn,
    input  logic                   nco_msb,
    output logic                   code_early,
    output logic                   code_prompt,
    output logic                   code_late,
    output logic [PHASE_WIDTH-1:0] code_phase,
    output logic                   epoch
);

    // Shift registers hold stage n in bit n-1, so stage 10 is bit 9.
    localparam logic [9:0]             C_ALL_ONES   = 10'h3FF;
    localparam logic [9:0]             C_G1_TAPS    = 10'b10_0000_0100; // s3, s10
    localparam logic [9:0]             C_G2_TAPS    = 10'b11_1010_0110; // s2,s3,s6,s8,s9,s10
    localparam logic [PHASE_WIDTH-1:0] C_LAST_PHASE = PHASE_WIDTH'(CODE_LENGTH - 1);

    // Two-stage selection mask for the G2 phase-select adder.
    function automatic logic [9:0] tap_pair(input int a, input int b);
        tap_pair = (10'd1 << (a - 1)) | (10'd1 << (b - 1));
    endfunction

    logic [9:0]             g1_q, g1_d;
    logic [9:0]             g2_q, g2_d;
    logic [5:0]             prn_q, prn_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic                   prompt_q, prompt_d;
    logic                   late_q, late_d;
    logic                   epoch_q, epoch_d;
    logic                   msb_dly_q, msb_dly_d;

    logic [9:0] w_tap_mask;
    logic       w_prn_valid;
    logic       w_g1_fb;
    logic       w_g2_fb;
    logic       w_early;
    logic       w_rise;
    logic       w_fall;

    // G2 phase-select taps per PRN; unknown PRNs select nothing and blank
    // the code output.
    always_comb begin
        w_tap_mask  = 10'd0;
        w_prn_valid = 1'b1;
        case (prn_q)
            6'd1:    w_tap_mask = tap_pair(2, 6);
            6'd2:    w_tap_mask = tap_pair(3, 7);
            6'd3:    w_tap_mask = tap_pair(4, 8);
            6'd4:    w_tap_mask = tap_pair(5, 9);
            6'd5:    w_tap_mask = tap_pair(1, 9);
            6'd6:    w_tap_mask = tap_pair(2, 10);
            6'd7:    w_tap_mask = tap_pair(1, 8);
            6'd8:    w_tap_mask = tap_pair(2, 9);
            6'd9:    w_tap_mask = tap_pair(3, 10);
            6'd10:   w_tap_mask = tap_pair(2, 3);
            6'd11:   w_tap_mask = tap_pair(3, 4);
            6'd12:   w_tap_mask = tap_pair(5, 6);
            6'd13:   w_tap_mask = tap_pair(6, 7);
            6'd14:   w_tap_mask = tap_pair(7, 8);
            6'd15:   w_tap_mask = tap_pair(8, 9);
            6'd16:   w_tap_mask = tap_pair(9, 10);
            6'd17:   w_tap_mask = tap_pair(1, 4);
            6'd18:   w_tap_mask = tap_pair(2, 5);
            6'd19:   w_tap_mask = tap_pair(3, 6);
            6'd20:   w_tap_mask = tap_pair(4, 7);
            6'd21:   w_tap_mask = tap_pair(5, 8);
            6'd22:   w_tap_mask = tap_pair(6, 9);
            6'd23:   w_tap_mask = tap_pair(1, 3);
            6'd24:   w_tap_mask = tap_pair(4, 6);
            6'd25:   w_tap_mask = tap_pair(5, 7);
            6'd26:   w_tap_mask = tap_pair(6, 8);
            6'd27:   w_tap_mask = tap_pair(7, 9);
            6'd28:   w_tap_mask = tap_pair(8, 10);
            6'd29:   w_tap_mask = tap_pair(1, 6);
            6'd30:   w_tap_mask = tap_pair(2, 7);
            6'd31:   w_tap_mask = tap_pair(3, 8);
            6'd32:   w_tap_mask = tap_pair(4, 9);
            default: w_prn_valid = 1'b0;
        endcase
    end

    assign w_g1_fb = ^(g1_q & C_G1_TAPS);
    assign w_g2_fb = ^(g2_q & C_G2_TAPS);
    assign w_early = w_prn_valid & (g1_q[9] ^ (^(g2_q & w_tap_mask)));
    assign w_rise  = nco_msb & ~msb_dly_q;
    assign w_fall  = ~nco_msb & msb_dly_q;

    always_comb begin
        g1_d      = g1_q;
        g2_d      = g2_q;
        prn_d     = prn_q;
        phase_d   = phase_q;
        prompt_d  = prompt_q;
        late_d    = late_q;
        epoch_d   = 1'b0;
        msb_dly_d = nco_msb;       // edge history tracks even while disabled

        if (init) begin
            prn_d    = prn;
            g1_d     = C_ALL_ONES;
            g2_d     = C_ALL_ONES;
            phase_d  = '0;
            prompt_d = 1'b0;
            late_d   = 1'b0;
        end else if (enable) begin
            // Delay line samples the early chip before this cycle's shift.
            if (w_rise || w_fall) begin
                late_d   = prompt_q;
                prompt_d = w_early;
            end
            if (w_rise) begin
                if (phase_q == C_LAST_PHASE) begin
                    // Realign at the wrap so shortened code lengths still
                    // restart on chip 0 of the Gold sequence.
                    phase_d = '0;
                    g1_d    = C_ALL_ONES;
                    g2_d    = C_ALL_ONES;
                    epoch_d = 1'b1;
                end else begin
                    phase_d = phase_q + 1'b1;
                    g1_d    = {g1_q[8:0], w_g1_fb};
                    g2_d    = {g2_q[8:0], w_g2_fb};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            g1_q      <= C_ALL_ONES;
            g2_q      <= C_ALL_ONES;
            prn_q     <= 6'd1;
            phase_q   <= '0;
            prompt_q  <= 1'b0;
            late_q    <= 1'b0;
            epoch_q   <= 1'b0;
            msb_dly_q <= 1'b0;
        end else begin
            g1_q      <= g1_d;
            g2_q      <= g2_d;
            prn_q     <= prn_d;
            phase_q   <= phase_d;
            prompt_q  <= prompt_d;
            late_q    <= late_d;
            epoch_q   <= epoch_d;
            msb_dly_q <= msb_dly_d;
        end
    end

    assign code_early  = w_early;
    assign code_prompt = prompt_q;
    assign code_late   = late_q;
    assign code_phase  = phase_q;
    assign epoch       = epoch_q;

endmodule
`default_nettype wire

// File: tb/tb_ca_code_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_ca_code_gen
// Description : Scoreboard bench for ca_code_gen. The stimulus process runs
//               a chip-index reference model over precomputed Gold-code
//               tables and queues the expected outputs for every code event;
//               a monitor pops and compares on the cycle the DUT reacts and
//               checks that outputs hold between events.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ca_code_gen;

    localparam int C_CL = 1023;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       init;
    logic [5:0] prn;
    logic       nco_msb;
    logic       code_early;
    logic       code_prompt;
    logic       code_late;
    logic [9:0] code_phase;
    logic       epoch;

    ca_code_gen #(
        .CODE_LENGTH (1023),
        .PHASE_WIDTH (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .init        (init),
        .prn         (prn),
        .nco_msb     (nco_msb),
        .code_early  (code_early),
        .code_prompt (code_prompt),
        .code_late   (code_late),
        .code_phase  (code_phase),
        .epoch       (epoch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       early;
        logic       prompt;
        logic       late;
        logic [9:0] phase;
        logic       epoch;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ep_cnt   = 0;

    // Gold-code chip tables, one 1023-chip epoch per PRN.
    bit tbl [1:32][0:C_CL-1];
    int ta  [1:32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
    int tb  [1:32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

    // Reference model state (chip-index view of the generator).
    int         m_prn;
    logic [9:0] m_phase;
    logic       m_prompt;
    logic       m_late;
    logic       m_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    endtask

    function automatic void build_tables();
        int g1 [1:10];
        int g2 [1:10];
        int f1, f2;
        for (int p = 1; p <= 32; p++) begin
            for (int s = 1; s <= 10; s++) begin
                g1[s] = 1;
                g2[s] = 1;
            end
            for (int n = 0; n < C_CL; n++) begin
                tbl[p][n] = bit'(g1[10] ^ g2[ta[p]] ^ g2[tb[p]]);
                f1 = g1[3] ^ g1[10];
                f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
                for (int s = 10; s >= 2; s--) begin
                    g1[s] = g1[s-1];
                    g2[s] = g2[s-1];
                end
                g1[1] = f1;
                g2[1] = f2;
            end
        end
    endfunction

    function automatic logic m_early();
        if (m_prn >= 1 && m_prn <= 32) return tbl[m_prn][int'(m_phase)];
        return 1'b0;
    endfunction

    function automatic void model_reset();
        m_prn    = 1;
        m_phase  = 10'd0;
        m_prompt = 1'b0;
        m_late   = 1'b0;
        m_prev   = 1'b0;
    endfunction

    // Apply this cycle's inputs to the model and queue the expected outputs
    // for any cycle in which the code state should react.
    function automatic void model_cycle();
        logic e;
        logic wrap;
        wrap = 1'b0;
        if (init) begin
            m_prn    = int'(prn);
            m_phase  = 10'd0;
            m_prompt = 1'b0;
            m_late   = 1'b0;
            q.push_back({m_early(), 1'b0, 1'b0, 10'd0, 1'b0});
        end else if (enable && (nco_msb != m_prev)) begin
            e        = m_early();
            m_late   = m_prompt;
            m_prompt = e;
            if (nco_msb) begin
                if (int'(m_phase) == C_CL - 1) begin
                    m_phase = 10'd0;
                    wrap    = 1'b1;
                end else begin
                    m_phase = m_phase + 10'd1;
                end
            end
            q.push_back({m_early(), m_prompt, m_late, m_phase, wrap});
        end
        m_prev = nco_msb;
    endfunction

    task automatic drive(input logic i_init, input logic [5:0] i_prn,
                         input logic i_en, input logic i_msb);
        init    = i_init;
        prn     = i_prn;
        enable  = i_en;
        nco_msb = i_msb;
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic toggle(input int half, input logic en);
        logic nv;
        nv = ~nco_msb;
        drive(1'b0, 6'($urandom_range(0, 63)), en, nv);
        for (int i = 1; i < half; i++) drive(1'b0, 6'($urandom_range(0, 63)), en, nv);
    endtask

    task automatic run_toggles(input int n);
        for (int i = 0; i < n; i++) toggle(int'($urandom_range(2, 3)), 1'b1);
    endtask

    task automatic do_init(input logic [5:0] p);
        drive(1'b1, p, 1'b1, 1'b0);
        drive(1'b0, 6'($urandom_range(0, 63)), 1'b1, 1'b0);
    endtask

    // Monitor: event cycles are recognised from the inputs alone; the DUT
    // must show the queued tuple after an event and hold it otherwise.
    initial begin : monitor
        exp_t cur_exp;
        exp_t got;
        logic mon_prev;
        logic ev;
        cur_exp  = {1'b1, 1'b0, 1'b0, 10'd0, 1'b0};
        mon_prev = 1'b0;
        ev       = 1'b0;
        forever begin
            @(posedge clk);
            if (!reset) begin
                mon_prev = 1'b0;
                cur_exp  = {1'b1, 1'b0, 1'b0, 10'd0, 1'b0};
                ev       = 1'b0;
            end else begin
                ev       = init || (enable && (nco_msb != mon_prev));
                mon_prev = nco_msb;
            end
            @(negedge clk);
            if (reset) begin
                if (ev) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        $display("FAIL scoreboard_underflow: got empty queue required entry at %0t", $time);
                    end else begin
                        cur_exp = q.pop_front();
                    end
                end
                got = {code_early, code_prompt, code_late, code_phase, epoch};
                chk("outputs{early,prompt,late,phase,epoch}", 32'(got), 32'(cur_exp));
                if (epoch) ep_cnt++;
                cur_exp.epoch = 1'b0;
            end
        end
    end

    initial begin : stimulus
        logic [9:0] pat;
        logic [9:0] saved;
        int         guard;
        int         prns [4] = '{1, 7, 19, 32};

        reset   = 1'b0;
        init    = 1'b0;
        enable  = 1'b0;
        prn     = 6'd0;
        nco_msb = 1'b0;
        build_tables();
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("reset_early",  32'(code_early),  32'd1);
        chk("reset_prompt", 32'(code_prompt), 32'd0);
        chk("reset_late",   32'(code_late),   32'd0);
        chk("reset_phase",  32'(code_phase),  32'd0);
        chk("reset_epoch",  32'(epoch),       32'd0);
        reset = 1'b1;

        // PRN1 opening chips at a fixed 4-clk half period.
        pat = 10'b1100100000;
        do_init(6'd1);
        for (int k = 0; k < 10; k++) begin
            chk("prn1_first_chips", 32'(code_early), 32'(pat[9-k]));
            chk("prn1_phase",       32'(code_phase), 32'(k));
            toggle(4, 1'b1);
            toggle(4, 1'b1);
        end

        // Full epoch per PRN, exactly one epoch pulse each.
        foreach (prns[j]) begin
            do_init(6'(prns[j]));
            ep_cnt = 0;
            run_toggles(2 * C_CL + 4);
            chk("epoch_count", 32'(ep_cnt), 32'd1);

            if (prns[j] == 19) begin
                // 40 clk with enable low while the DDS keeps toggling.
                saved = m_phase;
                for (int i = 0; i < 20; i++) toggle(2, 1'b0);
                chk("disabled_phase_hold", 32'(code_phase), 32'(saved));
                guard = 0;
                do begin
                    toggle(2, 1'b1);
                    guard++;
                end while (!nco_msb && guard < 3);
                chk("reenable_one_chip", 32'(code_phase),
                    32'((int'(saved) + 1) % C_CL));
            end
        end

        // init coinciding with a rise at chip 500, switching to PRN5.
        do_init(6'd7);
        guard = 0;
        while (!(m_phase == 10'd500 && !nco_msb) && guard < 5000) begin
            toggle(2, 1'b1);
            guard++;
        end
        chk("reach_phase_500", 32'(code_phase), 32'd500);
        ep_cnt = 0;
        drive(1'b1, 6'd5, 1'b1, 1'b1);
        chk("init_rise_phase", 32'(code_phase), 32'd0);
        chk("init_rise_early", 32'(code_early), 32'd1);
        chk("init_rise_epoch", 32'(epoch),      32'd0);
        drive(1'b0, 6'd0, 1'b1, 1'b1);
        run_toggles(300);
        chk("init_no_epoch", 32'(ep_cnt), 32'd0);

        // Asynchronous reset between clock edges.
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_early",  32'(code_early),  32'd1);
        chk("async_reset_prompt", 32'(code_prompt), 32'd0);
        chk("async_reset_late",   32'(code_late),   32'd0);
        chk("async_reset_phase",  32'(code_phase),  32'd0);
        chk("async_reset_epoch",  32'(epoch),       32'd0);
        q.delete();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Out-of-range PRN: blank code, counters and epoch still run.
        do_init(6'd40);
        ep_cnt = 0;
        run_toggles(2 * C_CL + 4);
        chk("bad_prn_epoch_count", 32'(ep_cnt), 32'd1);
        chk("bad_prn_early",       32'(code_early), 32'd0);

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
